int_to_float: RTL
=================

INT_TO_FLOAT -- requirements
Module: int_to_float

Interface
REQ-001 SHALL have parameter RND_MODE, default 0; 0 = round-to-nearest-even, 1 = truncate toward zero.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-low; the block is held in reset while reset = 0.
REQ-004 SHALL have port start, input, 1, request a conversion; sampled only in IDLE.
REQ-005 SHALL have port signed_in, input, 1, 1 = I is two's complement, 0 = I is unsigned; sampled with start.
REQ-006 SHALL have port I, input, 32, integer operand; sampled with start.
REQ-007 SHALL have port F, output, 32, IEEE-754 single-precision result, in the format consumed by float_addition operands A/B.
REQ-008 SHALL have port inexact, output, 1, set when rounding or truncation discarded nonzero bits.
REQ-009 SHALL have port busy, output, 1, high in states ABS, NORM and ROUND.
REQ-010 SHALL have port done, output, 1, one-cycle pulse in state DONE.

Function
REQ-011 SHALL implement the FSM states IDLE, ABS, NORM, ROUND and DONE.
REQ-012 IDLE SHALL go to ABS on the edge where start = 1, capturing I, signed_in and RND_MODE behaviour.
REQ-013 ABS SHALL capture sign = signed_in & I[31] and mag = sign ? -I : I (32-bit), and SHALL load exp = 158.
REQ-014 ABS SHALL go to DONE when mag = 0 (F = 0x00000000, inexact = 0), and otherwise to NORM.
REQ-015 NORM SHALL shift mag left by one bit and decrement exp per cycle while mag[31] = 0, and SHALL go to ROUND on the first cycle in which mag[31] = 1.
REQ-016 ROUND SHALL form man = mag[30:8], guard = mag[7] and sticky = OR of mag[6:0].
REQ-017 In ROUND, when RND_MODE = 0, man SHALL be incremented iff guard & (sticky | man[0]); when RND_MODE = 1, man SHALL never be incremented.
REQ-018 A mantissa carry-out SHALL set man = 0 and exp = exp + 1.
REQ-019 inexact SHALL equal guard | sticky.
REQ-020 ROUND SHALL go to DONE, registering F = {sign, exp[7:0], man} and inexact on that edge.
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-022 F and inexact SHALL hold their value until the next ROUND->DONE or ABS->DONE transition.
REQ-023 Latency SHALL be fixed: with start sampled at edge k and lz = leading zeros of mag, done SHALL be high after edge k+3+lz for nonzero mag, and after edge k+1 for zero.
REQ-024 The maximum latency SHALL be 34 edges (mag = 1, lz = 31).
REQ-025 start asserted while busy = 1 or in DONE SHALL be ignored and SHALL NOT be queued.
REQ-026 start held high continuously SHALL launch a new conversion on the first edge spent in IDLE.
REQ-027 Signed I = 0x80000000 SHALL be handled as magnitude 2^31 with no overflow and zero NORM shifts.
REQ-028 exp SHALL be 9 bits internally; the result can never overflow, and no infinity or NaN SHALL ever be produced.

Reset
REQ-029 reset = 0 SHALL asynchronously force state IDLE, F = 0, inexact = 0, busy = 0, done = 0, mag = 0, exp = 0 and sign = 0.
REQ-030 Reset asserted mid-conversion SHALL abort it with no done pulse.
REQ-031 After reset release, the first start SHALL behave as from power-up.

Verification
REQ-032 Unsigned I = 0x00000001, start at edge k -> F = 0x3F800000, inexact = 0, done high after edge k+34.
REQ-033 Signed I = 0xFFFFFFFF -> F = 0xBF800000; signed I = 0x80000000 -> F = 0xCF000000, done after edge k+3; unsigned I = 0x80000000 -> F = 0x4F000000.
REQ-034 Unsigned I = 0xFFFFFFFF -> F = 0x4F800000, inexact = 1 (carry into exponent); with RND_MODE = 1 -> F = 0x4F7FFFFF, inexact = 1.
REQ-035 Unsigned I = 0x01000001 (tie, even) -> F = 0x4B800000, inexact = 1; I = 0x01000003 -> F = 0x4B800002, inexact = 1.
REQ-036 I = 0 -> F = 0x00000000, done after edge k+1; a second start pulsed while busy -> no effect, only one done pulse.
REQ-037 reset driven low during NORM of I = 1 -> busy = 0, done stays 0, F = 0 immediately; a following start of I = 3 -> F = 0x40400000.

Source files
------------

// File: rtl/int_to_float.sv
// int_to_float: multi-cycle 32-bit integer to IEEE-754 single-precision converter.
//
// A conversion walks IDLE -> ABS -> NORM (one cycle per leading zero) -> ROUND -> DONE.
// Zero skips straight from ABS to DONE. Latency is fixed by the leading-zero count only.
//
// Parameters
//   RND_MODE   0 = round-to-nearest-even, 1 = truncate toward zero
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-low
//   start      request a conversion; only sampled in IDLE, never queued
//   signed_in  1 = I is two's complement, 0 = unsigned (sampled with start)
//   I          integer operand (sampled with start)
//   F          single-precision result, held until the next conversion completes
//   inexact    nonzero bits were discarded when forming F
//   busy       high in ABS, NORM and ROUND
//   done       one-cycle pulse in DONE
module int_to_float #(
    parameter int unsigned RND_MODE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_in,
    input  logic [31:0] I,
    output logic [31:0] F,
    output logic        inexact,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ABS   = 3'd1;
    localparam logic [2:0] S_NORM  = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic ROUND_NEAREST = (RND_MODE == 0);

    // Exponent of a value whose MSB sits at bit 31: 31 + bias 127.
    localparam logic [8:0] EXP_TOP = 9'd158;

    logic [2:0]  state_q, state_d;
    logic [31:0] i_q, i_d;
    logic        signed_q, signed_d;
    logic        sign_q, sign_d;
    logic [31:0] mag_q, mag_d;
    logic [8:0]  exp_q, exp_d;
    logic [31:0] f_q, f_d;
    logic        inexact_q, inexact_d;

    // Absolute value of the captured operand. -0x80000000 wraps to 0x80000000,
    // which is exactly the unsigned magnitude 2^31 we want.
    logic        abs_sign;
    logic [31:0] abs_mag;

    assign abs_sign = signed_q & i_q[31];
    assign abs_mag  = abs_sign ? (~i_q + 32'd1) : i_q;

    // Rounding of the normalised magnitude (mag_q[31] is the hidden bit).
    logic [22:0] man_raw;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] man_sum;
    logic [7:0]  exp_rnd;

    assign man_raw  = mag_q[30:8];
    assign guard    = mag_q[7];
    assign sticky   = |mag_q[6:0];
    assign round_up = ROUND_NEAREST & guard & (sticky | man_raw[0]);
    assign man_sum  = {1'b0, man_raw} + {23'd0, round_up};
    // On carry-out man_sum[22:0] is already zero; only the exponent moves.
    assign exp_rnd  = exp_q[7:0] + {7'd0, man_sum[23]};

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        signed_d  = signed_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        f_d       = f_q;
        inexact_d = inexact_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    i_d      = I;
                    signed_d = signed_in;
                    state_d  = S_ABS;
                end
            end
            S_ABS: begin
                sign_d = abs_sign;
                mag_d  = abs_mag;
                exp_d  = EXP_TOP;
                if (abs_mag == 32'd0) begin
                    f_d       = 32'd0;
                    inexact_d = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (mag_q[31]) begin
                    state_d = S_ROUND;
                end else begin
                    mag_d = {mag_q[30:0], 1'b0};
                    exp_d = exp_q - 9'd1;
                end
            end
            S_ROUND: begin
                f_d       = {sign_q, exp_rnd, man_sum[22:0]};
                inexact_d = guard | sticky;
                state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            i_q       <= 32'd0;
            signed_q  <= 1'b0;
            sign_q    <= 1'b0;
            mag_q     <= 32'd0;
            exp_q     <= 9'd0;
            f_q       <= 32'd0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            signed_q  <= signed_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            f_q       <= f_d;
            inexact_q <= inexact_d;
        end
    end

    assign F       = f_q;
    assign inexact = inexact_q;
    assign busy    = (state_q == S_ABS) || (state_q == S_NORM) || (state_q == S_ROUND);
    assign done    = (state_q == S_DONE);

endmodule
